// File: rtl/serial_comparator_lsb.sv
// serial_comparator_lsb: LSB-first bit-serial magnitude comparator with start/ready/valid handshake
module serial_comparator_lsb #(
  parameter int WIDTH = 8,
  parameter bit SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic             Flout,
  output logic             Feout,
  output logic             Fgout
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic e_q, e_d, l_q, l_d, g_q, g_d;
  logic busy_q, busy_d, valid_q, valid_d;
  logic fl_q, fl_d, fe_q, fe_d, fg_q, fg_d;
  logic a, b, last, inv, ne, e_n, l_n, g_n;
  always_comb begin
    a = sa_q[0];
    b = sb_q[0];
    last = cnt_q == CW'(WIDTH - 1);
    inv = SIGNED && last;
    ne = a ^ b;
    e_n = e_q & ~ne;
    l_n = ne ? (inv ? a & ~b : ~a & b) : l_q;
    g_n = ne ? (inv ? ~a & b : a & ~b) : g_q;
    state_d = state_q;
    sa_d = sa_q;
    sb_d = sb_q;
    cnt_d = cnt_q;
    e_d = e_q;
    l_d = l_q;
    g_d = g_q;
    busy_d = busy_q;
    valid_d = valid_q;
    fl_d = fl_q;
    fe_d = fe_q;
    fg_d = fg_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      sa_d = A;
      sb_d = B;
      cnt_d = '0;
      e_d = 1'b1;
      l_d = 1'b0;
      g_d = 1'b0;
      busy_d = 1'b1;
    end else if (state_q == RUN) begin
      sa_d = sa_q >> 1;
      sb_d = sb_q >> 1;
      cnt_d = cnt_q + CW'(1);
      e_d = e_n;
      l_d = l_n;
      g_d = g_n;
      if (last) begin
        state_d = DONE;
        busy_d = 1'b0;
        valid_d = 1'b1;
        fl_d = l_n;
        fe_d = e_n;
        fg_d = g_n;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      cnt_q <= '0;
      e_q <= 1'b1;
      l_q <= 1'b0;
      g_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      fl_q <= 1'b0;
      fe_q <= 1'b0;
      fg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      cnt_q <= cnt_d;
      e_q <= e_d;
      l_q <= l_d;
      g_q <= g_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      fl_q <= fl_d;
      fe_q <= fe_d;
      fg_q <= fg_d;
    end
  end
  assign ready = state_q == IDLE;
  assign busy = busy_q;
  assign valid = valid_q;
  assign Flout = fl_q;
  assign Feout = fe_q;
  assign Fgout = fg_q;
endmodule

// File: tb/tb_serial_comparator_lsb.sv
// tb_serial_comparator_lsb: scoreboard bench comparing unsigned and signed instances against integer compares
module tb_serial_comparator_lsb;
  localparam int W = 8;
  typedef struct {logic [2:0] f; int due;} exp_t;
  logic clk = 0, rst = 1, start = 1;
  logic [W-1:0] A = 0, B = 0;
  logic rdy0, bsy0, vld0, fl0, fe0, fg0;
  logic rdy1, bsy1, vld1, fl1, fe1, fg1;
  int cyc = 0, checks = 0, errors = 0, free_at = 0;
  exp_t q0[$], q1[$];
  logic [2:0] last0 = 0, last1 = 0;

  serial_comparator_lsb #(.WIDTH(W), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(rdy0), .busy(bsy0), .valid(vld0), .Flout(fl0), .Feout(fe0), .Fgout(fg0));
  serial_comparator_lsb #(.WIDTH(W), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(rdy1), .busy(bsy1), .valid(vld1), .Flout(fl1), .Feout(fe1), .Fgout(fg1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // {lt, eq, gt} from plain integer comparison
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    int x, y;
    x = (s && a[W-1]) ? int'(a) - (1 << W) : int'(a);
    y = (s && b[W-1]) ? int'(b) - (1 << W) : int'(b);
    return {x < y, x == y, x > y};
  endfunction

  task automatic mon(input int i, input logic v, input logic [2:0] f);
    exp_t h;
    int n;
    logic ev;
    n = i ? q1.size() : q0.size();
    if (n > 0) h = i ? q1[0] : q0[0];
    ev = n > 0 && h.due == cyc;
    check($sformatf("valid%0d", i), v, ev);
    if (ev) begin
      check($sformatf("flags%0d", i), f, h.f);
      if (i) begin last1 = h.f; void'(q1.pop_front()); end
      else begin last0 = h.f; void'(q0.pop_front()); end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, vld0, {fl0, fe0, fg0});
    mon(1, vld1, {fl1, fe1, fg1});
  end

  // one cycle of stimulus; model tracks when the next start can be accepted
  task automatic tick(input logic r, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int e;
    @(negedge clk);
    check("ready0", rdy0, cyc >= free_at - 1);
    check("ready1", rdy1, cyc >= free_at - 1);
    check("busy0", bsy0, cyc < free_at - 2 && cyc >= free_at - W - 2);
    check("busy1", bsy1, cyc < free_at - 2 && cyc >= free_at - W - 2);
    check("hold0", {fl0, fe0, fg0}, last0);
    check("hold1", {fl1, fe1, fg1}, last1);
    rst = r;
    start = s;
    A = a;
    B = b;
    e = cyc + 1;
    if (r) begin
      free_at = e + 1;
      q0.delete();
      q1.delete();
      last0 = 0;
      last1 = 0;
    end else if (s && e >= free_at) begin
      q0.push_back('{ref_cmp(a, b, 0), e + W});
      q1.push_back('{ref_cmp(a, b, 1), e + W});
      free_at = e + W + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, $urandom, $urandom);
  endtask

  task automatic cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    tick(0, 1, a, b);
    idle(W + 1);
  endtask

  initial begin
    logic [W-1:0] da[7], db[7];
    da = '{8'h5A, 8'h80, 8'h01, 8'h00, 8'hFF, 8'h7F, 8'hFF};
    db = '{8'h5A, 8'h7F, 8'h00, 8'hFF, 8'hFE, 8'h80, 8'hFF};
    tick(1, 1, $urandom, $urandom);
    tick(1, 1, $urandom, $urandom);
    idle(2);
    for (int i = 0; i < 7; i++) cmp(da[i], db[i]);
    tick(0, 1, 8'h10, 8'h20);
    idle(3);
    tick(0, 1, 8'hFF, 8'h00);
    idle(W);
    for (int i = 0; i < 40; i++) tick(0, 1, $urandom, $urandom);
    idle(W + 2);
    for (int i = 0; i < 400; i++) tick(0, $urandom_range(0, 2) == 0, $urandom, $urandom);
    idle(W + 2);
    tick(0, 1, 8'h03, 8'h01);
    idle(4);
    tick(1, 0, 8'h03, 8'h01);
    idle(W + 2);
    cmp(8'h03, 8'h01);
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, $urandom, $urandom);
      idle($urandom_range(0, W + 2));
      tick(1, $urandom_range(0, 1), $urandom, $urandom);
      idle(2);
    end
    idle(W + 3);
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_comparator_lsb.md
# serial_comparator_lsb

Bit-serial magnitude comparator that walks two WIDTH-bit operands least-significant bit first, one bit per clock. It produces the same less/equal/greater flag triple that our MSB-first cascade comparator cells produce. The cascade resolves from the top bit down; this block resolves in the other direction, letting each more significant differing bit override the verdict so far. It sits beside the datapath as a low-area comparator with a start/ready/valid handshake, for use where a WIDTH-cell cascade is too large.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥2.
- SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only when ready=1.
- A  in  WIDTH  operand A; sampled on the accepting edge only.
- B  in  WIDTH  operand B; sampled on the accepting edge only.
- ready  out  1  high in IDLE only; decoded from state.
- busy  out  1  high in RUN; registered.
- valid  out  1  one-cycle pulse, high in DONE; registered.
- Flout  out  1  result A<B; registered, held until next DONE.
- Feout  out  1  result A==B; registered, held until next DONE.
- Fgout  out  1  result A>B; registered, held until next DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, ready=1, busy=0, valid=0, Flout=Feout=Fgout=0, bit counter=0, working flags E=1, L=0, G=0.
- IDLE → RUN on start=1:
  - Load A and B into shift registers SA and SB.
  - Set working flags E=1, L=0, G=0.
  - Set counter=0.
- start in RUN or DONE is ignored. It is not queued and does not change the operands.
- RUN, per cycle, with a=SA[0], b=SB[0] and k=counter:
  - If a==b, the working flags are unchanged.
  - If a!=b, E=0.
    - Non-sign bit (SIGNED=0, or k<WIDTH-1): L=~a&b, G=a&~b.
    - Sign bit (SIGNED=1 and k==WIDTH-1): inverted, L=a&~b, G=~a&b.
  - Shift SA and SB right by one. Increment counter.
  - When k==WIDTH-1: copy the updated working flags to Flout/Feout/Fgout and go to DONE.
- DONE: valid=1 for exactly one cycle, then IDLE unconditionally.
- Result flags are exactly one-hot after the first completed compare. They stay 000 from reset until then.
- The counter is $clog2(WIDTH)+1 bits wide and never wraps within a compare.
- Reset asserted in any state:
  - The next state is IDLE with all reset values.
  - Any compare in progress is dropped with no valid pulse.
  - Flags clear to 000.

## Timing
- Let edge 0 be the edge that samples start=1 with ready=1.
- After edge 0: ready=0, busy=1.
- Edges 1..WIDTH process bits 0..WIDTH-1.
- After edge WIDTH: busy=0, valid=1, and flags show the new result.
- After edge WIDTH+1: valid=0 and ready=1. A start here is accepted on edge WIDTH+2.
- Latency from start accept to valid is WIDTH cycles. Throughput is one compare per WIDTH+2 cycles.
- rst and start high on the same edge: rst wins and nothing is accepted.
- A and B may change freely after edge 0.

## Test plan
- Reset: hold rst 2 cycles, with start=1 during reset → ready=1, busy=0, valid=0, flags 000, no acceptance.
- Equal operands (WIDTH=8, SIGNED=0): A=0x5A, B=0x5A, start → valid exactly 8 cycles after the accepting edge, Feout=1, Flout=Fgout=0.
- MSB override (WIDTH=8, SIGNED=0):
  - A=0x80, B=0x7F → Fgout=1. Bit 0 alone would give L; bit 7 must override it.
  - A=0x01, B=0x00 → Fgout=1.
  - A=0x00, B=0xFF → Flout=1.
- Signed (WIDTH=8, SIGNED=1):
  - A=0x80, B=0x7F → Flout=1.
  - A=0xFF, B=0xFE → Fgout=1.
  - A=0x7F, B=0x80 → Fgout=1.
  - A=0xFF, B=0xFF → Feout=1.
- Start while busy: accept A=0x10, B=0x20; 3 cycles later pulse start with A=0xFF, B=0x00 → that start is ignored, one valid pulse, Flout=1. Back-to-back starts held high → compares accepted every 10 cycles.
- Reset mid-operation: accept A=0x03, B=0x01; assert rst at RUN bit 4 → next cycle IDLE, flags 000, no valid pulse. A new compare of A=0x03, B=0x01 then completes with Fgout=1.
